// File: rtl/parallel_vector_accumulator.sv
// Multi-lane vector integrator: accumulates PARALLEL channel bins over acc_len frames and
// dumps each finished integration with address, last-sample and per-lane overflow tags.
module parallel_vector_accumulator #(
  parameter int unsigned DIN_WIDTH     = 32,
  parameter int unsigned PARALLEL      = 4,
  parameter int unsigned VECTOR_LEN    = 64,
  parameter int unsigned DOUT_WIDTH    = 64,
  parameter string       DATA_TYPE     = "signed",
  parameter int unsigned ACC_LEN_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ACC_LEN_WIDTH-1:0]       acc_len,
  input  logic                           sync_in,
  input  logic [PARALLEL*DIN_WIDTH-1:0]  din,
  input  logic                           din_valid,
  output logic [PARALLEL*DOUT_WIDTH-1:0] dout,
  output logic                           dout_valid,
  output logic [$clog2(VECTOR_LEN)-1:0]  dout_addr,
  output logic                           dout_last,
  output logic [PARALLEL-1:0]            ovf,
  output logic                           sync_err
);
  localparam int unsigned AW       = $clog2(VECTOR_LEN);
  localparam int unsigned LaneW    = DOUT_WIDTH + 1;
  localparam int unsigned RamW     = PARALLEL * LaneW;
  localparam bit          IsSigned = (DATA_TYPE == "signed");
  localparam logic [AW-1:0] LastAddr = AW'(VECTOR_LEN - 1);

  typedef enum logic [0:0] {StIdle, StAcc} state_e;
  state_e state_q, state_d;

  logic sample, restart, sync_bad;
  logic [AW-1:0] addr_q, addr_d, cur_addr;
  logic [ACC_LEN_WIDTH-1:0] frame_q, frame_d, cur_frame;
  logic [ACC_LEN_WIDTH-1:0] len_q, len_d, cur_len, len_new;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (din_valid && sync_in) state_d = StAcc;
      StAcc:   state_d = StAcc;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sample   = 1'b0;
    restart  = 1'b0;
    sync_bad = 1'b0;
    unique case (state_q)
      StIdle: begin
        sample  = din_valid && sync_in;
        restart = din_valid && sync_in;
      end
      StAcc: begin
        sample   = din_valid;
        sync_bad = din_valid && sync_in && (addr_q != '0);
        restart  = din_valid && sync_in && (addr_q != '0);
      end
      default: ;
    endcase
  end

  assign len_new = (acc_len == '0) ? ACC_LEN_WIDTH'(1) : acc_len;

  // A restarting sample is itself address 0 of frame 0 under the freshly latched length.
  always_comb begin
    cur_addr  = restart ? '0 : addr_q;
    cur_frame = restart ? '0 : frame_q;
    cur_len   = restart ? len_new : len_q;
    addr_d    = addr_q;
    frame_d   = frame_q;
    len_d     = len_q;
    if (sample) begin
      addr_d  = cur_addr + AW'(1);
      frame_d = cur_frame;
      len_d   = cur_len;
      if (cur_addr == LastAddr) begin
        if (cur_frame == cur_len - ACC_LEN_WIDTH'(1)) begin
          frame_d = '0;
          len_d   = len_new;
        end else begin
          frame_d = cur_frame + ACC_LEN_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      frame_q <= '0;
      len_q   <= ACC_LEN_WIDTH'(1);
    end else begin
      addr_q  <= addr_d;
      frame_q <= frame_d;
      len_q   <= len_d;
    end
  end

  // Pipeline: s1 = read issued, s2 = RAM data, s3 = sum registered, then write + output.
  logic s1_valid, s2_valid, s3_valid;
  logic s1_first, s2_first, s1_dump, s2_dump, s3_dump;
  logic [AW-1:0] s1_addr, s2_addr, s3_addr;
  logic [PARALLEL*DIN_WIDTH-1:0] s1_din, s2_din;
  logic [RamW-1:0] rd_q1, rd_q2, sum_d, s3_word;
  logic [RamW-1:0] mem [VECTOR_LEN];
  logic [PARALLEL*DOUT_WIDTH-1:0] s3_dout;
  logic [PARALLEL-1:0] s3_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s1_valid <= sample;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk) begin
    s1_first <= (cur_frame == '0);
    s1_dump  <= (cur_frame == cur_len - ACC_LEN_WIDTH'(1));
    s1_addr  <= cur_addr;
    s1_din   <= din;
    s2_first <= s1_first;
    s2_dump  <= s1_dump;
    s2_addr  <= s1_addr;
    s2_din   <= s1_din;
    s3_dump  <= s2_dump;
    s3_addr  <= s2_addr;
    s3_word  <= sum_d;
  end

  always_ff @(posedge clk) begin
    if (s3_valid && !rst) mem[s3_addr] <= s3_word;
    rd_q1 <= mem[cur_addr];
    rd_q2 <= rd_q1;
  end

  for (genvar k = 0; k < PARALLEL; k++) begin : g_lane
    logic [DIN_WIDTH-1:0]  x, xn;
    logic [DOUT_WIDTH-1:0] ext, acc, sum;
    logic [DOUT_WIDTH:0]   full;
    logic                  acc_ovf, sign_ovf, step_ovf;

    assign x        = s2_din[k*DIN_WIDTH +: DIN_WIDTH];
    assign xn       = ~x;
    assign ext      = (IsSigned && x[DIN_WIDTH-1]) ? ~DOUT_WIDTH'(xn) : DOUT_WIDTH'(x);
    assign acc      = rd_q2[k*LaneW +: DOUT_WIDTH];
    assign acc_ovf  = rd_q2[k*LaneW + DOUT_WIDTH];
    assign full     = {1'b0, acc} + {1'b0, ext};
    assign sum      = full[DOUT_WIDTH-1:0];
    assign sign_ovf = (acc[DOUT_WIDTH-1] == ext[DOUT_WIDTH-1]) &&
                      (sum[DOUT_WIDTH-1] != acc[DOUT_WIDTH-1]);
    assign step_ovf = IsSigned ? sign_ovf : full[DOUT_WIDTH];
    // Frame 0 seeds the bin from din alone, so stale RAM and old overflow flags drop out.
    assign sum_d[k*LaneW +: LaneW] = s2_first ? {1'b0, ext} : {acc_ovf | step_ovf, sum};

    assign s3_dout[k*DOUT_WIDTH +: DOUT_WIDTH] = s3_word[k*LaneW +: DOUT_WIDTH];
    assign s3_ovf[k] = s3_word[k*LaneW + DOUT_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_addr  <= '0;
      dout_last  <= 1'b0;
      ovf        <= '0;
      sync_err   <= 1'b0;
    end else begin
      dout_valid <= s3_valid && s3_dump;
      dout_last  <= s3_valid && s3_dump && (s3_addr == LastAddr);
      sync_err   <= sync_bad;
      if (s3_valid && s3_dump) begin
        dout      <= s3_dout;
        dout_addr <= s3_addr;
        ovf       <= s3_ovf;
      end
    end
  end

endmodule

// File: tb/tb_parallel_vector_accumulator.sv
// Directed bench: a signed 2-lane instance and an unsigned 8->9 bit instance share clk/rst.
module tb_parallel_vector_accumulator;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  acc_len;
  logic        sync_in, din_valid;
  logic [31:0] din;
  logic [63:0] dout;
  logic        dout_valid, dout_last, sync_err;
  logic [3:0]  dout_addr;
  logic [1:0]  ovf;
  logic        u_sync_in, u_din_valid;
  logic [15:0] u_din;
  logic [17:0] u_dout;
  logic        u_dout_valid, u_dout_last, u_sync_err;
  logic [3:0]  u_dout_addr;
  logic [1:0]  u_ovf;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  bit          exp_v  [8192];
  bit          exp_se [8192];
  logic [70:0] exp_w  [8192];
  bit          uexp_v [8192];
  logic [24:0] uexp_w [8192];

  parallel_vector_accumulator #(
    .DIN_WIDTH(16), .PARALLEL(2), .VECTOR_LEN(16), .DOUT_WIDTH(32),
    .DATA_TYPE("signed"), .ACC_LEN_WIDTH(8)
  ) u_dut (
    .clk(clk), .rst(rst), .acc_len(acc_len), .sync_in(sync_in), .din(din),
    .din_valid(din_valid), .dout(dout), .dout_valid(dout_valid), .dout_addr(dout_addr),
    .dout_last(dout_last), .ovf(ovf), .sync_err(sync_err)
  );

  parallel_vector_accumulator #(
    .DIN_WIDTH(8), .PARALLEL(2), .VECTOR_LEN(16), .DOUT_WIDTH(9),
    .DATA_TYPE("unsigned"), .ACC_LEN_WIDTH(8)
  ) u_dut_u (
    .clk(clk), .rst(rst), .acc_len(acc_len), .sync_in(u_sync_in), .din(u_din),
    .din_valid(u_din_valid), .dout(u_dout), .dout_valid(u_dout_valid),
    .dout_addr(u_dout_addr), .dout_last(u_dout_last), .ovf(u_ovf), .sync_err(u_sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input bit v, input bit s, input logic [15:0] a0, input logic [15:0] a1);
    din_valid = v;
    sync_in   = s;
    din       = {a1, a0};
  endtask

  task automatic u_drive(input bit v, input bit s, input logic [7:0] a0, input logic [7:0] a1);
    u_din_valid = v;
    u_sync_in   = s;
    u_din       = {a1, a0};
  endtask

  // Called at the negedge where the sample is driven; the dump appears 4 cycles later.
  task automatic expect_dump(input int a, input logic [31:0] e0, input logic [31:0] e1);
    exp_v[cyc+4] = 1'b1;
    exp_w[cyc+4] = {(a == 15), 4'(a), e1, e0, 2'b00};
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 16'h0, 16'h0);
    u_drive(0, 0, 8'h0, 8'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total += 8;
    if (dout !== 64'h0) $display("FAIL reset_dout got %h want 0", dout); else passed++;
    if (dout_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", dout_valid); else passed++;
    if (dout_addr !== 4'h0) $display("FAIL reset_addr got %h want 0", dout_addr); else passed++;
    if (dout_last !== 1'b0) $display("FAIL reset_last got %b want 0", dout_last); else passed++;
    if (ovf !== 2'b00) $display("FAIL reset_ovf got %b want 0", ovf); else passed++;
    if (sync_err !== 1'b0) $display("FAIL reset_sync_err got %b want 0", sync_err); else passed++;
    if (u_dout !== 18'h0) $display("FAIL reset_u_dout got %h want 0", u_dout); else passed++;
    if (u_dout_valid !== 1'b0) $display("FAIL reset_u_valid got %b want 0", u_dout_valid);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_integrate();
    int a, f;
    acc_len = 8'd4;
    for (int c = 0; c < 134; c++) begin
      @(negedge clk);
      total++;
      if (dout_valid !== exp_v[cyc] || sync_err !== exp_se[cyc] ||
          (exp_v[cyc] ? ({dout_last, dout_addr, dout, ovf} !== exp_w[cyc]) : (dout_last !== 1'b0)))
        $display("FAIL integrate cyc=%0d got v=%b se=%b w=%h want v=%b se=%b w=%h", cyc,
                 dout_valid, sync_err, {dout_last, dout_addr, dout, ovf}, exp_v[cyc],
                 exp_se[cyc], exp_w[cyc]);
      else passed++;
      if (c < 128) begin
        a = c % 16;
        f = (c / 16) % 4;
        drive(1, a == 0, 16'(a), 16'hFFFF);
        if (f == 3) expect_dump(a, 32'(4 * a), 32'hFFFF_FFFC);
      end else drive(0, 0, 16'h0, 16'h0);
    end
  endtask

  task automatic test_gaps();
    int a, f, k;
    bit v;
    pulse_reset();
    acc_len = 8'd4;
    k = 0;
    for (int c = 0; c < 440; c++) begin
      @(negedge clk);
      total++;
      if (dout_valid !== exp_v[cyc] || sync_err !== exp_se[cyc] ||
          (exp_v[cyc] ? ({dout_last, dout_addr, dout, ovf} !== exp_w[cyc]) : (dout_last !== 1'b0)))
        $display("FAIL gaps cyc=%0d got v=%b se=%b w=%h want v=%b se=%b w=%h", cyc,
                 dout_valid, sync_err, {dout_last, dout_addr, dout, ovf}, exp_v[cyc],
                 exp_se[cyc], exp_w[cyc]);
      else passed++;
      v = (c >= 300) ? 1'b1 : 1'($urandom_range(1, 0));
      if (k < 128 && v) begin
        a = k % 16;
        f = (k / 16) % 4;
        drive(1, a == 0, 16'(a), 16'hFFFF);
        if (f == 3) expect_dump(a, 32'(4 * a), 32'hFFFF_FFFC);
        k++;
      end else begin
        // Unqualified sync and junk data on idle cycles must be ignored.
        drive(0, 1'($urandom_range(1, 0)), 16'($urandom), 16'($urandom));
      end
    end
    total++;
    if (k !== 128) $display("FAIL gaps_count got %0d samples want 128", k); else passed++;
  endtask

  task automatic test_acc_len_change();
    int a, f;
    pulse_reset();
    acc_len = 8'd1;
    for (int c = 0; c < 118; c++) begin
      @(negedge clk);
      total++;
      if (dout_valid !== exp_v[cyc] || sync_err !== exp_se[cyc] ||
          (exp_v[cyc] ? ({dout_last, dout_addr, dout, ovf} !== exp_w[cyc]) : (dout_last !== 1'b0)))
        $display("FAIL acc_len cyc=%0d got v=%b se=%b w=%h want v=%b se=%b w=%h", cyc,
                 dout_valid, sync_err, {dout_last, dout_addr, dout, ovf}, exp_v[cyc],
                 exp_se[cyc], exp_w[cyc]);
      else passed++;
      if (c < 112) begin
        a = c % 16;
        f = c / 16;
        if (c == 3 * 16 + 5) acc_len = 8'd3;
        drive(1, a == 0, 16'(100 + 16 * f + a), 16'(-(a + 1)));
        if (f <= 3) expect_dump(a, 32'(100 + 16 * f + a), 32'(-(a + 1)));
        else if (f == 6) expect_dump(a, 32'(540 + 3 * a), 32'(-3 * (a + 1)));
      end else drive(0, 0, 16'h0, 16'h0);
    end
  endtask

  task automatic test_unsigned_ovf();
    int a, f;
    pulse_reset();
    acc_len = 8'd3;
    for (int c = 0; c < 102; c++) begin
      @(negedge clk);
      total++;
      if (u_dout_valid !== uexp_v[cyc] || u_sync_err !== 1'b0 ||
          (uexp_v[cyc] ? ({u_dout_last, u_dout_addr, u_dout, u_ovf} !== uexp_w[cyc])
                       : (u_dout_last !== 1'b0)))
        $display("FAIL unsigned_ovf cyc=%0d got v=%b se=%b w=%h want v=%b se=0 w=%h", cyc,
                 u_dout_valid, u_sync_err, {u_dout_last, u_dout_addr, u_dout, u_ovf},
                 uexp_v[cyc], uexp_w[cyc]);
      else passed++;
      if (c < 96) begin
        a = c % 16;
        f = c / 16;
        u_drive(1, a == 0, (f < 3) ? 8'd255 : 8'd1, 8'd1);
        if (f == 2 || f == 5) begin
          uexp_v[cyc+4] = 1'b1;
          uexp_w[cyc+4] = (f == 2) ? {(a == 15), 4'(a), 9'd3, 9'd253, 2'b01}
                                   : {(a == 15), 4'(a), 9'd3, 9'd3, 2'b00};
        end
      end else u_drive(0, 0, 8'h0, 8'h0);
    end
  endtask

  task automatic test_sync_err();
    int a, f;
    pulse_reset();
    acc_len = 8'd4;
    for (int c = 0; c < 107; c++) begin
      @(negedge clk);
      total++;
      if (dout_valid !== exp_v[cyc] || sync_err !== exp_se[cyc] ||
          (exp_v[cyc] ? ({dout_last, dout_addr, dout, ovf} !== exp_w[cyc]) : (dout_last !== 1'b0)))
        $display("FAIL sync_err cyc=%0d got v=%b se=%b w=%h want v=%b se=%b w=%h", cyc,
                 dout_valid, sync_err, {dout_last, dout_addr, dout, ovf}, exp_v[cyc],
                 exp_se[cyc], exp_w[cyc]);
      else passed++;
      if (c < 37) begin
        drive(1, (c % 16) == 0, 16'd1000, 16'd500);
      end else if (c < 101) begin
        a = (c - 37) % 16;
        f = (c - 37) / 16;
        drive(1, a == 0, 16'(a + 2), 16'(-(f + 1)));
        if (c == 37) exp_se[cyc+1] = 1'b1;
        if (f == 3) expect_dump(a, 32'(4 * a + 8), 32'(-10));
      end else drive(0, 0, 16'h0, 16'h0);
    end
  endtask

  // Starts from the framing left by test_sync_err, so dout still holds a nonzero dump.
  task automatic test_reset_mid_frame();
    int a, f;
    acc_len = 8'd4;
    for (int c = 0; c < 81; c++) begin
      @(negedge clk);
      total++;
      if (dout_valid !== exp_v[cyc] || sync_err !== exp_se[cyc] ||
          (exp_v[cyc] ? ({dout_last, dout_addr, dout, ovf} !== exp_w[cyc]) : (dout_last !== 1'b0)))
        $display("FAIL reset_mid cyc=%0d got v=%b se=%b w=%h want v=%b se=%b w=%h", cyc,
                 dout_valid, sync_err, {dout_last, dout_addr, dout, ovf}, exp_v[cyc],
                 exp_se[cyc], exp_w[cyc]);
      else passed++;
      rst = 1'b0;
      if (c == 24) begin
        total++;
        if ({dout, dout_valid, dout_addr, dout_last, ovf, sync_err} !== 73'h0)
          $display("FAIL reset_mid_zero got dout=%h v=%b addr=%h last=%b ovf=%b se=%b want 0",
                   dout, dout_valid, dout_addr, dout_last, ovf, sync_err);
        else passed++;
      end
      if (c < 23) begin
        drive(1, (c % 16) == 0, 16'd50, 16'd50);
      end else if (c == 23) begin
        rst = 1'b1;
        drive(1, 1, 16'd50, 16'd50);
      end else if (c < 35) begin
        drive(1, 0, 16'd77, 16'd77);
      end else if (c < 67) begin
        acc_len = 8'd2;
        a = (c - 35) % 16;
        f = (c - 35) / 16;
        drive(1, a == 0, 16'(a), 16'd3);
        if (f == 1) expect_dump(a, 32'(2 * a), 32'd6);
      end else drive(0, 0, 16'h0, 16'h0);
    end
  endtask

  initial begin
    rst     = 1'b1;
    acc_len = 8'd0;
    drive(0, 0, 16'h0, 16'h0);
    u_drive(0, 0, 8'h0, 8'h0);
    test_reset();
    test_integrate();
    test_gaps();
    test_acc_len_change();
    test_unsigned_ovf();
    test_sync_err();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
